apb_master_if: RTL

- APB requester that drives the encoder/decoder register block from a host-side command port.
- Accepts one command per handshake and sequences it as an APB transfer: SETUP, then a fixed-length ACCESS, then read capture.
- Returns write completions and read data on a single-cycle response strobe.
- Sits between the testbench/host CPU model and the APB slave register file.

---
 rtl/apb_master_if.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/apb_master_if.sv
// ----------------------------------------------------------------------------
// apb_master_if : host command port to APB requester (SETUP/ACCESS/CAPTURE)
// Optional PREADY wait extension enabled by `define APB_MASTER_PREADY_EN
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module apb_master_if #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int ACCESS_CYCLES   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  output logic                       rsp_write,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       busy,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PWDATA,
`ifdef APB_MASTER_PREADY_EN
  input  logic                       PREADY,
`endif
  input  logic [AMBA_WORD-1:0]       PRDATA
);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
    $error("apb_master_if: ACCESS_CYCLES must be within 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [AMBA_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                       write_q, write_d;
  logic [AMBA_WORD-1:0]       wdata_q, wdata_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       rsp_write_q, rsp_write_d;
  logic [AMBA_WORD-1:0]       rdata_q, rdata_d;
  logic                       slave_ready;

`ifdef APB_MASTER_PREADY_EN
  assign slave_ready = PREADY;
`else
  assign slave_ready = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          write_d = cmd_write;
          wdata_d = cmd_wdata;
          cnt_d   = CNT_INIT;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // Counter parks at zero while a slave stretches the access.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (slave_ready) begin
          if (write_q) begin
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        rdata_d     = PRDATA;
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE   = (state_q == ACCESS);
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rdata_q;

endmodule

`default_nettype wire
